wb_daq_sram_arbiter: RTL and testbench

Round-robin arbiter that shares the single SRAM write port between the DAQ channels. Each channel presents one aggregated word with a `start_sram` request. The arbiter grants one channel at a time, writes its word into that channel's circular region of SRAM, and pulses `grant` back to the channel. It sits between the `wb_daq_channel` instances and the SRAM controller, and also reports per-channel buffer wrap status.

---
 rtl/wb_daq_pkg.sv | 25 ++
 rtl/wb_daq_rr_pick.sv | 39 +++
 rtl/wb_daq_sram_arbiter.sv | 119 +++++++++++
 tb/tb_wb_daq_sram_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_daq_pkg.sv
// Shared definitions for the DAQ SRAM write-side arbiter and its helpers:
// FSM state encoding and the channel-index / region-size arithmetic.
package wb_daq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } arb_state_e;

  // Width of a channel index; a one-channel build still needs one bit.
  function automatic int cw_of(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

  // Words owned by each channel's circular region.
  function automatic int region_words(input int aw, input int channels);
    return 1 << (aw - cw_of(channels));
  endfunction

  localparam int DEF_DW       = 32;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_AW       = 10;
  localparam int DEF_REGION   = region_words(DEF_AW, DEF_CHANNELS);

endpackage

// File: rtl/wb_daq_rr_pick.sv
// Combinational round-robin picker: first eligible bit searching upward
// from (last + 1), wrapping modulo the channel count.
module wb_daq_rr_pick
  import wb_daq_pkg::*;
#(
  parameter  int channels = DEF_CHANNELS,
  localparam int CW       = cw_of(channels)
) (
  input  logic [channels-1:0] i_eligible,
  input  logic [CW-1:0]       i_last,
  output logic [channels-1:0] o_pick,
  output logic [CW-1:0]       o_idx,
  output logic                o_valid
);

  logic          w_found;
  logic [CW-1:0] w_cand;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    o_idx   = '0;
    o_pick  = '0;
    // Index arithmetic wraps naturally because channels is a power of two.
    for (int k = 1; k <= channels; k++) begin
      w_cand = i_last + CW'(k);
      if (!w_found && i_eligible[w_cand]) begin
        w_found = 1'b1;
        o_idx   = w_cand;
      end
    end
    if (w_found) o_pick[o_idx] = 1'b1;
  end

  assign o_valid = w_found;

endmodule

// File: rtl/wb_daq_sram_arbiter.sv
// Round-robin arbiter sharing one SRAM write port among DAQ channels; each
// channel writes into its own circular region and gets sticky wrap status.
module wb_daq_sram_arbiter
  import wb_daq_pkg::*;
#(
  parameter int dw       = DEF_DW,
  parameter int channels = DEF_CHANNELS,
  parameter int aw       = DEF_AW
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic [channels-1:0]    start_sram,
  input  logic [channels*dw-1:0] data_in,
  input  logic [channels-1:0]    enable_mask,
  input  logic                   clear,
  input  logic                   sram_ack,
  output logic [channels-1:0]    grant,
  output logic                   sram_we,
  output logic [aw-1:0]          sram_addr,
  output logic [dw-1:0]          sram_data,
  output logic                   busy,
  output logic [channels-1:0]    wrapped
);

  localparam int CW = cw_of(channels);
  localparam int PW = aw - CW;

  arb_state_e          r_state;
  logic [PW-1:0]       r_ptr [channels];
  logic [CW-1:0]       r_last;
  logic [CW-1:0]       r_idx;
  logic [channels-1:0] r_grant;
  logic                r_we;
  logic [aw-1:0]       r_addr;
  logic [dw-1:0]       r_data;
  logic                r_busy;
  logic [channels-1:0] r_wrapped;

  logic [dw-1:0]       w_words [channels];
  logic [channels-1:0] w_pick_oh;
  logic [CW-1:0]       w_pick_idx;
  logic                w_pick_valid;
  logic [PW-1:0]       w_ptr_sel;

  always_comb begin
    for (int i = 0; i < channels; i++) w_words[i] = data_in[i*dw +: dw];
  end

  // A grant issued alongside clear already targets the cleared pointer.
  assign w_ptr_sel = clear ? '0 : r_ptr[w_pick_idx];

  wb_daq_rr_pick #(.channels(channels)) u_pick (
    .i_eligible (start_sram & enable_mask),
    .i_last     (r_last),
    .o_pick     (w_pick_oh),
    .o_idx      (w_pick_idx),
    .o_valid    (w_pick_valid)
  );

  // NOTE: state is updated only with non-blocking assignments so every read
  // in this block sees the pre-edge value, independent of statement order.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state   <= ST_IDLE;
      r_last    <= CW'(channels - 1);
      r_idx     <= '0;
      r_grant   <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_wrapped <= '0;
      // NOTE: the pointer array is a handful of flops, not a RAM, so it is
      // reset like any other register.
      for (int i = 0; i < channels; i++) r_ptr[i] <= '0;
    end else begin
      r_grant <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_idx   <= w_pick_idx;
            r_addr  <= {w_pick_idx, w_ptr_sel};
            r_data  <= w_words[w_pick_idx];
            r_grant <= w_pick_oh;
            r_we    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (sram_ack) begin
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= r_idx;
            r_state <= ST_IDLE;
            if (!clear) begin
              r_ptr[r_idx] <= r_ptr[r_idx] + 1'b1;
              if (&r_ptr[r_idx]) r_wrapped[r_idx] <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Later assignments win, so clear overrides any same-cycle increment.
      if (clear) begin
        r_wrapped <= '0;
        for (int i = 0; i < channels; i++) r_ptr[i] <= '0;
      end
    end
  end

  assign grant     = r_grant;
  assign sram_we   = r_we;
  assign sram_addr = r_addr;
  assign sram_data = r_data;
  assign busy      = r_busy;
  assign wrapped   = r_wrapped;

endmodule

// File: tb/tb_wb_daq_sram_arbiter.sv
// Directed bench for wb_daq_sram_arbiter: a per-cycle behavioural model plus
// literal expectations on the grant log for each scenario.
module tb_wb_daq_sram_arbiter;

  logic         wb_clk = 1'b0;
  logic         wb_rst;
  logic [3:0]   start_sram;
  logic [127:0] data_in;
  logic [3:0]   enable_mask;
  logic         clear;
  logic         sram_ack;
  logic [3:0]   grant;
  logic         sram_we;
  logic [9:0]   sram_addr;
  logic [31:0]  sram_data;
  logic         busy;
  logic [3:0]   wrapped;

  int n_checks = 0;
  int n_fail   = 0;

  wb_daq_sram_arbiter #(.dw(32), .channels(4), .aw(10)) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .start_sram  (start_sram),
    .data_in     (data_in),
    .enable_mask (enable_mask),
    .clear       (clear),
    .sram_ack    (sram_ack),
    .grant       (grant),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_data   (sram_data),
    .busy        (busy),
    .wrapped     (wrapped)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: transaction-level view with integer pointers.
  bit          m_valid = 0;
  bit          m_busy;
  int          m_idx, m_last, m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_grant, m_wrap;
  int          m_ptr [4];

  always @(posedge wb_clk) begin
    if (wb_rst) begin
      m_valid = 1; m_busy = 0; m_idx = 0; m_last = 3; m_addr = 0;
      m_data = '0; m_grant = '0; m_wrap = '0;
      for (int i = 0; i < 4; i++) m_ptr[i] = 0;
    end else if (m_valid) begin
      m_grant = '0;
      if (!m_busy) begin
        for (int off = 1; off <= 4; off++) begin
          int c;
          c = (m_last + off) % 4;
          if (start_sram[c] && enable_mask[c] && m_grant == 0) begin
            m_idx   = c;
            m_addr  = c * 256 + (clear ? 0 : m_ptr[c]);
            m_data  = data_in[c*32 +: 32];
            m_grant = 4'(1 << c);
            m_busy  = 1;
          end
        end
      end else if (sram_ack) begin
        m_busy = 0;
        m_last = m_idx;
        if (!clear) begin
          if (m_ptr[m_idx] == 255) m_wrap[m_idx] = 1'b1;
          m_ptr[m_idx] = (m_ptr[m_idx] + 1) % 256;
        end
      end
      if (clear) begin
        m_wrap = '0;
        for (int i = 0; i < 4; i++) m_ptr[i] = 0;
      end
    end
  end

  // Grant log and write-strobe counter, observed from the DUT.
  int          log_ch[$];
  logic [9:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [3:0]  log_wrap[$];
  int          log_cyc[$];
  int          cyc = 0;
  int          we_hi = 0;

  always @(posedge wb_clk) cyc++;

  always @(negedge wb_clk) begin
    if (m_valid && !wb_rst) begin
      check("grant", grant, m_grant);
      check("sram_we", sram_we, m_busy);
      check("busy", busy, m_busy);
      check("sram_addr", sram_addr, m_addr);
      check("sram_data", sram_data, m_data);
      check("wrapped", wrapped, m_wrap);
      if (sram_we === 1'b1) we_hi++;
      if (grant != 0) begin
        for (int i = 0; i < 4; i++) if (grant[i]) log_ch.push_back(i);
        log_addr.push_back(sram_addr);
        log_data.push_back(sram_data);
        log_wrap.push_back(wrapped);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic do_reset();
    wb_rst = 1; start_sram = '0; clear = 0; enable_mask = 4'hF; sram_ack = 1;
    repeat (2) @(posedge wb_clk);
    #1 wb_rst = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(posedge wb_clk); #1;
      if (busy === 1'b0) break;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic single(input int ch, input logic [31:0] d);
    start_sram[ch] = 1'b1;
    data_in[ch*32 +: 32] = d;
    @(posedge wb_clk); #1;
    start_sram[ch] = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int we0;
    int exp_t2 [6] = '{0, 1, 2, 3, 0, 1};
    int exp_t5 [10] = '{0, 2, 3, 0, 2, 3, 0, 1, 2, 3};
    int exp_a2 [6] = '{'h000, 'h100, 'h200, 'h300, 'h001, 'h101};

    data_in = '0;
    wb_rst = 1; start_sram = '0; clear = 0; enable_mask = 4'hF; sram_ack = 1;
    repeat (3) @(posedge wb_clk);
    #1 wb_rst = 0;
    @(negedge wb_clk);
    check("rst_grant", grant, 4'b0000);
    check("rst_we", sram_we, 1'b0);
    check("rst_addr", sram_addr, 10'h000);
    check("rst_data", sram_data, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_wrapped", wrapped, 4'b0000);
    @(posedge wb_clk); #1;

    // Single channel-2 write, then a second one to see the pointer advance.
    base = log_ch.size();
    single(2, 32'hDEADBEEF);
    single(2, 32'h12345678);
    check("t1_count", log_ch.size() - base, 2);
    check("t1_ch", log_ch[base], 2);
    check("t1_addr", log_addr[base], 10'h200);
    check("t1_data", log_data[base], 32'hDEADBEEF);
    check("t1_addr2", log_addr[base+1], 10'h201);

    // All channels requesting continuously: rotation and 2-cycle spacing.
    do_reset();
    data_in = {32'h33330000, 32'h22220000, 32'h11110000, 32'h00000000};
    base = log_ch.size();
    start_sram = 4'hF;
    repeat (12) @(posedge wb_clk);
    #1 start_sram = '0;
    wait_idle();
    check("t2_count", log_ch.size() - base, 6);
    for (int k = 0; k < 6; k++) begin
      check("t2_order", log_ch[base+k], exp_t2[k]);
      check("t2_addr", log_addr[base+k], exp_a2[k]);
      if (k > 0) check("t2_spacing", log_cyc[base+k] - log_cyc[base+k-1], 2);
    end

    // Ack held off for 5 cycles while channel 3 waits.
    sram_ack = 0;
    start_sram[0] = 1; data_in[31:0] = 32'hA5A50000;
    @(posedge wb_clk); #1;
    start_sram[0] = 0;
    start_sram[3] = 1; data_in[127:96] = 32'h3333BEEF;
    base = log_ch.size(); we0 = we_hi;
    repeat (4) @(posedge wb_clk);
    #1 sram_ack = 1;
    @(posedge wb_clk); #1;
    check("t3_grants_in_wait", log_ch.size() - base, 1);
    check("t3_we_cycles", we_hi - we0, 5);
    @(posedge wb_clk); #1;
    start_sram[3] = 0;
    wait_idle();
    check("t3_ch0", log_ch[base], 0);
    check("t3_ch0_addr", log_addr[base], 10'h002);
    check("t3_ch0_data", log_data[base], 32'hA5A50000);
    check("t3_ch3", log_ch[base+1], 3);
    check("t3_ch3_addr", log_addr[base+1], 10'h301);
    check("t3_ch3_gap", log_cyc[base+1] - log_cyc[base], 6);

    // Channel 1 masked off, then re-enabled.
    do_reset();
    base = log_ch.size();
    enable_mask = 4'b1101;
    start_sram = 4'hF;
    repeat (12) @(posedge wb_clk);
    #1 enable_mask = 4'hF;
    repeat (8) @(posedge wb_clk);
    #1 start_sram = '0;
    wait_idle();
    check("t5_count", log_ch.size() - base, 10);
    for (int k = 0; k < 10; k++) check("t5_order", log_ch[base+k], exp_t5[k]);

    // Channel 1 fills its 256-word region and wraps.
    do_reset();
    base = log_ch.size();
    data_in[63:32] = 32'h1111CAFE;
    start_sram = 4'b0010;
    repeat (513) @(posedge wb_clk);
    #1 start_sram = '0;
    wait_idle();
    check("t4_count", log_ch.size() - base, 257);
    check("t4_first", log_addr[base], 10'h100);
    check("t4_last", log_addr[base+255], 10'h1FF);
    check("t4_wrap_addr", log_addr[base+256], 10'h100);
    check("t4_wrap_before", log_wrap[base+255], 4'b0000);
    check("t4_wrap_after", log_wrap[base+256], 4'b0010);
    check("t4_wrapped_now", wrapped, 4'b0010);

    // Bring channel 3 to pointer 7, then clear coincident with its ack.
    base = log_ch.size();
    for (int k = 0; k < 7; k++) single(3, 32'h30000000 + k);
    check("t6_ptr6_addr", log_addr[base+6], 10'h306);
    sram_ack = 0;
    start_sram[3] = 1; data_in[127:96] = 32'h3000BEEF;
    @(posedge wb_clk); #1;
    start_sram[3] = 0;
    @(posedge wb_clk); #1;
    sram_ack = 1; clear = 1;
    @(posedge wb_clk); #1;
    clear = 0;
    check("t6_inflight_addr", log_addr[base+7], 10'h307);
    check("t6_wrapped_cleared", wrapped, 4'b0000);
    check("t6_idle", busy, 1'b0);
    base = log_ch.size();
    single(3, 32'hC0FFEE00);
    single(1, 32'hC0FFEE01);
    check("t6_ch3_addr", log_addr[base], 10'h300);
    check("t6_ch1_addr", log_addr[base+1], 10'h100);

    repeat (2) @(posedge wb_clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
